// File: rtl/snake_screen_pkg.sv
// Shared definitions for the snake screen sequencer.
// Holds the scheduler state encoding, the Screen_Sel codes used by the
// per-screen VGA modules, and a helper that sizes the shared frame counter.
package snake_screen_pkg;

    typedef enum logic [2:0] {
        ST_READY     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    localparam logic [1:0] SCR_READY = 2'd0;
    localparam logic [1:0] SCR_COUNT = 2'd1;
    localparam logic [1:0] SCR_PLAY  = 2'd2;
    localparam logic [1:0] SCR_OVER  = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/snake_key_edge.sv
// Rising-edge detector for a debounced key level.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   key  - debounced key level
//   rise - high for the cycle in which key is 1 and was 0 on the previous cycle
// The previous-value register resets to 1 so a key held through reset does
// not produce a spurious edge when reset releases.
module snake_key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= key;
    end

    // Combinational compare so the FSM reacts in the same clock the key is sampled.
    assign rise = key & ~prev;

endmodule

// File: rtl/snake_screen_sequencer.sv
// Screen scheduler for the snake VGA game.
// Sequences READY -> COUNTDOWN -> PLAY <-> PAUSE -> OVER -> READY and drives
// the enables/selects consumed by the per-screen VGA control modules.
// All timing is counted in frames using Frame_Tick.
// Ports:
//   CLK, RST     - pixel clock, synchronous active-high reset
//   Frame_Tick   - one-cycle pulse per frame
//   Start_Key    - debounced start key level
//   Pause_Key    - debounced pause key level
//   Game_Over    - one-cycle pulse from game logic
//   Screen_Sel   - 0 READY, 1 COUNTDOWN, 2 PLAY/PAUSE, 3 OVER
//   Ready_En     - blinking ready-banner enable
//   Count_En     - countdown digit visible
//   Count_Digit  - countdown digit to render
//   Game_Run     - game logic may advance
//   Over_En      - game-over banner enable
module snake_screen_sequencer
    import snake_screen_pkg::*;
#(
    parameter int BLINK_FRAMES     = 30,
    parameter int COUNT_FRAMES     = 60,
    parameter int COUNT_START      = 3,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Frame_Tick,
    input  logic       Start_Key,
    input  logic       Pause_Key,
    input  logic       Game_Over,
    output logic [1:0] Screen_Sel,
    output logic       Ready_En,
    output logic       Count_En,
    output logic [1:0] Count_Digit,
    output logic       Game_Run,
    output logic       Over_En
);

    localparam int CW = $clog2(max3(BLINK_FRAMES, COUNT_FRAMES, OVER_HOLD_FRAMES)) + 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_FRAMES - 1);
    localparam logic [CW-1:0] OVER_LAST  = CW'(OVER_HOLD_FRAMES - 1);
    localparam logic [1:0]    DIGIT_FIRST = 2'(COUNT_START);

    logic start_rise, pause_rise;

    snake_key_edge u_start_edge (.clk(CLK), .rst(RST), .key(Start_Key), .rise(start_rise));
    snake_key_edge u_pause_edge (.clk(CLK), .rst(RST), .key(Pause_Key), .rise(pause_rise));

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          blink, blink_nx;
    logic [1:0]    digit, digit_nx;
    logic [1:0]    sel_nx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_READY;
            cnt         <= '0;
            blink       <= 1'b1;
            digit       <= 2'd0;
            Screen_Sel  <= SCR_READY;
            Ready_En    <= 1'b1;
            Count_En    <= 1'b0;
            Count_Digit <= 2'd0;
            Game_Run    <= 1'b0;
            Over_En     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            blink       <= blink_nx;
            digit       <= digit_nx;
            // Outputs are registered from the next-state values so they
            // update on the same edge as the state itself.
            Screen_Sel  <= sel_nx;
            Ready_En    <= (state_nx == ST_READY) & blink_nx;
            Count_En    <= (state_nx == ST_COUNTDOWN);
            Count_Digit <= digit_nx;
            Game_Run    <= (state_nx == ST_PLAY);
            Over_En     <= (state_nx == ST_OVER);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        blink_nx = blink;
        digit_nx = digit;
        case (state)
            ST_READY: begin
                // A start edge wins over a coincident tick; that tick is dropped.
                if (start_rise) begin
                    state_nx = ST_COUNTDOWN;
                    cnt_nx   = '0;
                    digit_nx = DIGIT_FIRST;
                end else if (Frame_Tick) begin
                    if (cnt == BLINK_LAST) begin
                        blink_nx = ~blink;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_COUNTDOWN: begin
                if (Frame_Tick) begin
                    if (cnt == COUNT_LAST) begin
                        cnt_nx = '0;
                        if (digit == 2'd1) begin
                            state_nx = ST_PLAY;
                            digit_nx = 2'd0;
                        end else begin
                            digit_nx = digit - 2'd1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // Game_Over has priority over a simultaneous pause edge.
                if (Game_Over) begin
                    state_nx = ST_OVER;
                    cnt_nx   = '0;
                end else if (pause_rise) begin
                    state_nx = ST_PAUSE;
                    cnt_nx   = '0;
                end
            end
            ST_PAUSE: begin
                if (Game_Over) begin
                    state_nx = ST_OVER;
                    cnt_nx   = '0;
                end else if (pause_rise) begin
                    state_nx = ST_PLAY;
                    cnt_nx   = '0;
                end
            end
            ST_OVER: begin
                if (Frame_Tick) begin
                    if (cnt == OVER_LAST) begin
                        state_nx = ST_READY;
                        cnt_nx   = '0;
                        blink_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_READY;
                cnt_nx   = '0;
                blink_nx = 1'b1;
                digit_nx = 2'd0;
            end
        endcase

        case (state_nx)
            ST_COUNTDOWN:      sel_nx = SCR_COUNT;
            ST_PLAY, ST_PAUSE: sel_nx = SCR_PLAY;
            ST_OVER:           sel_nx = SCR_OVER;
            default:           sel_nx = SCR_READY;
        endcase
    end

endmodule
